// File: rtl/conv_requant.sv
// Conv output requantiser: bias add, multiply, rounding shift and int8 saturation
// in a 3-stage pipeline, plus row/frame position tracking for the downstream pool.
module conv_requant #(
    parameter int MAP_WIDTH = 28,
    parameter int ACC_W     = 32,
    parameter int MULT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [MULT_W-1:0]       mult,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    output logic                    valid_out,
    output logic signed [7:0]       pixel_out,
    output logic                    eol,
    output logic                    all_done
);

    localparam int SW    = ACC_W + 1;
    localparam int PW    = ACC_W + MULT_W + 1;
    localparam int RW    = PW + 1;
    localparam int TOTAL = MAP_WIDTH * MAP_WIDTH;
    localparam int COL_W = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(MAP_WIDTH - 1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(TOTAL - 1);
    localparam logic signed [RW-1:0] SAT_HI   = 127;
    localparam logic signed [RW-1:0] SAT_LO   = -128;

    logic              v1_q, v2_q, v3_q;
    logic [SW-1:0]     sum_d, sum_q;
    logic [MULT_W-1:0] mult1_q;
    logic [4:0]        shift1_q, shift2_q;
    logic              relu1_q, relu2_q;
    logic [PW-1:0]     prod_d, prod_q;
    logic signed [7:0] pix_d, pix_q;
    logic [COL_W-1:0]  col_d, col_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              done_d, done_q;

    logic [RW-1:0]        prod_x, rnd;
    logic signed [RW-1:0] rsum, r, lo;

    always_comb begin
        sum_d = {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
        // Equal-width unsigned multiply of the sign-extended sum and zero-extended
        // multiplier yields the correct two's-complement product in the low PW bits.
        prod_d = {{MULT_W{sum_q[SW-1]}}, sum_q} * {{(ACC_W + 1){1'b0}}, mult1_q};
    end

    always_comb begin
        prod_x = {prod_q[PW-1], prod_q};
        rnd    = ({{(RW - 1){1'b0}}, 1'b1} << shift2_q) >> 1;
        rsum   = prod_x + rnd;
        r      = rsum >>> shift2_q;
        lo     = relu2_q ? '0 : SAT_LO;
        pix_d  = pix_q;
        if (v2_q) begin
            if (r > SAT_HI) begin
                pix_d = 8'sd127;
            end else if (r < lo) begin
                pix_d = lo[7:0];
            end else begin
                pix_d = r[7:0];
            end
        end
    end

    always_comb begin
        col_d  = col_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (v3_q) begin
            col_d = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sum_q    <= '0;
            mult1_q  <= '0;
            shift1_q <= '0;
            shift2_q <= '0;
            relu1_q  <= 1'b0;
            relu2_q  <= 1'b0;
            prod_q   <= '0;
            pix_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            v1_q     <= valid_in;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            sum_q    <= sum_d;
            mult1_q  <= mult;
            shift1_q <= shift;
            relu1_q  <= relu_en;
            prod_q   <= prod_d;
            shift2_q <= shift1_q;
            relu2_q  <= relu1_q;
            pix_q    <= pix_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign valid_out = v3_q;
    assign pixel_out = pix_q;
    assign eol       = v3_q && (col_q == LAST_COL);
    assign all_done  = done_q;

endmodule

// File: tb/tb_conv_requant.sv
// Randomised and directed bench for conv_requant against an integer-arithmetic
// reference model with a fixed 3-cycle latency queue.
module tb_conv_requant;

    localparam int W = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_in = 1'b0;
    logic signed [31:0] acc_in = '0;
    logic signed [31:0] bias = '0;
    logic [15:0]       mult = '0;
    logic [4:0]        shift = '0;
    logic              relu_en = 1'b0;
    logic              valid_out;
    logic signed [7:0] pixel_out;
    logic              eol;
    logic              all_done;

    conv_requant #(.MAP_WIDTH(W), .ACC_W(32), .MULT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .acc_in    (acc_in),
        .bias      (bias),
        .mult      (mult),
        .shift     (shift),
        .relu_en   (relu_en),
        .valid_out (valid_out),
        .pixel_out (pixel_out),
        .eol       (eol),
        .all_done  (all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     v;
        longint pix;
    } exp_t;

    exp_t   pipe[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint last_pix = 0;
    int     col_m = 0;
    int     cnt_m = 0;
    bit     done_m = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint ref_pix(input int a, input int b, input int unsigned m,
                                       input int sh, input bit relu);
        longint p;
        longint lo;
        p = (longint'(a) + longint'(b)) * longint'(m);
        if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
        p  = p >>> sh;
        lo = relu ? 0 : -128;
        if (p > 127) return 127;
        if (p < lo) return lo;
        return p;
    endfunction

    task automatic model_reset();
        exp_t b;
        b.v = 1'b0;
        b.pix = 0;
        pipe.delete();
        repeat (3) pipe.push_back(b);
        last_pix = 0;
        col_m = 0;
        cnt_m = 0;
        done_m = 1'b0;
    endtask

    task automatic cycle(input bit v, input int a, input int b, input int unsigned m,
                         input int sh, input bit r);
        exp_t e;
        exp_t n;
        @(negedge clk);
        e = pipe.pop_front();
        chk("valid_out", longint'(valid_out), longint'(e.v));
        if (e.v) last_pix = e.pix;
        chk("pixel_out", longint'(pixel_out), last_pix);
        chk("eol", longint'(eol), longint'(e.v && (col_m == W - 1)));
        chk("all_done", longint'(all_done), longint'(done_m));
        if (e.v) begin
            col_m = (col_m == W - 1) ? 0 : col_m + 1;
            cnt_m++;
            if (cnt_m == W * W) begin
                cnt_m = 0;
                done_m = 1'b1;
            end
        end
        valid_in = v;
        acc_in   = a;
        bias     = b;
        mult     = m[15:0];
        shift    = sh[4:0];
        relu_en  = r;
        n.v   = v;
        n.pix = v ? ref_pix(a, b, m, sh, r) : 0;
        pipe.push_back(n);
    endtask

    task automatic bubble();
        cycle(1'b0, 0, 0, 1, 0, 1'b0);
    endtask

    task automatic rand_pixel(input bit v);
        int          a;
        int          b;
        int unsigned m;
        case ($urandom_range(0, 2))
            0: a = int'($urandom_range(0, 600)) - 300;
            1: a = int'($urandom_range(0, 200000)) - 100000;
            default: a = int'($urandom());
        endcase
        b = int'($urandom_range(0, 2000)) - 1000;
        m = $urandom_range(0, 65535);
        cycle(v, a, b, m, int'($urandom_range(0, 31)), 1'(($urandom() & 1)));
    endtask

    task automatic directed(input string tag, input int a, input int b, input int unsigned m,
                            input int sh, input bit r, input longint exp);
        cycle(1'b1, a, b, m, sh, r);
        repeat (3) bubble();
        chk(tag, longint'(pixel_out), exp);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out", longint'(valid_out), 0);
        chk("rst_pixel_out", longint'(pixel_out), 0);
        chk("rst_eol", longint'(eol), 0);
        chk("rst_all_done", longint'(all_done), 0);
        rst = 1'b1;
        model_reset();

        directed("pix_75", 100, 0, 3, 2, 1'b0, 75);
        directed("sat_hi", 1000, 24, 1, 3, 1'b0, 127);
        directed("sat_lo", -1000, 0, 1, 0, 1'b0, -128);
        directed("neg_round", -5, 0, 1, 1, 1'b0, -2);
        directed("relu_clamp", -5, 0, 1, 1, 1'b1, 0);

        // Alternating valid with a distinct config on every pixel.
        cycle(1'b1, 100, 0, 3, 2, 1'b0);
        bubble();
        cycle(1'b1, -5, 0, 1, 1, 1'b0);
        bubble();
        cycle(1'b1, -5, 0, 1, 1, 1'b1);
        bubble();
        cycle(1'b1, 1000, 24, 1, 3, 1'b0);
        bubble();
        for (int i = 0; i < 8; i++) rand_pixel(i % 2 == 0);

        for (int i = 0; i < 120; i++) rand_pixel(($urandom() % 3) != 0);

        // Two pixels in flight when a short reset pulse lands mid-cycle.
        cycle(1'b1, 100, 0, 3, 2, 1'b0);
        cycle(1'b1, 1000, 24, 1, 3, 1'b0);
        bubble();
        #2 rst = 1'b0;
        #1;
        chk("async_valid_out", longint'(valid_out), 0);
        chk("async_pixel_out", longint'(pixel_out), 0);
        chk("async_eol", longint'(eol), 0);
        chk("async_all_done", longint'(all_done), 0);
        #1 rst = 1'b1;
        model_reset();
        repeat (6) bubble();

        for (int i = 0; i < W * W; i++) rand_pixel(1'b1);
        repeat (3) bubble();
        bubble();
        chk("frame_done", longint'(all_done), 1);

        for (int i = 0; i < 40; i++) rand_pixel(($urandom() & 1) == 1);
        repeat (4) bubble();
        chk("done_sticky", longint'(all_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
